// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared constants and types for the layer-1 -> layer-2 ping-pong feature buffer.
// Layer-2 buffers reuse these definitions.
package pingpong_buf_ctrl_pkg;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int CNT_W      = 8;
    localparam int BANK_WORDS = 144;
    localparam int BANK0_BASE = 0;
    localparam int BANK1_BASE = 200;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BANK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_e;

    function automatic logic [ADDR_W-1:0] bank_base(input logic bank);
        return bank ? ADDR_W'(BANK1_BASE) : ADDR_W'(BANK0_BASE);
    endfunction
endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Writer, consumer and RAM-port signals of the ping-pong buffer controller.
interface pingpong_buf_ctrl_if;
    import pingpong_buf_ctrl_pkg::*;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              cons_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_bank;
    logic              bank_full;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  wr_valid, wr_data, cons_ready, mem_rdata,
        output wr_ready, out_valid, out_data, out_last, out_bank, bank_full,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_valid, wr_data, cons_ready, mem_rdata,
        input  wr_ready, out_valid, out_data, out_last, out_bank, bank_full,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pingpong_buf_ctrl_bank.sv
// Full flags and write/read bank pointers of the two-bank buffer.
module pingpong_bank_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill,
    input  logic       free,
    output logic [1:0] full,
    output logic       wr_bank,
    output logic       rd_bank
);
    // fill and free always touch different banks, so both may land in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (fill) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (free) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end
endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: write counter, single-port RAM arbitration
// (writes win) and the frame read sequencer.
module pingpong_buf_ctrl
    import pingpong_buf_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    pingpong_buf_ctrl_if.slave  bus
);
    logic [1:0]       full;
    logic             wr_bank, rd_bank;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    rd_state_e        state, state_nxt;
    logic             wr_acc, fill, free, rd_issue;
    logic             rd_pending, last_pending, out_bank_q, bank_full_q;

    pingpong_bank_tracker u_tracker (
        .clk     (clk),
        .reset   (reset),
        .fill    (fill),
        .free    (free),
        .full    (full),
        .wr_bank (wr_bank),
        .rd_bank (rd_bank)
    );

    assign bus.wr_ready = !full[wr_bank];
    assign wr_acc       = bus.wr_valid && !full[wr_bank];
    assign fill         = wr_acc && (wr_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_bank] && bus.cons_ready) state_nxt = READ;
            READ:    if (rd_issue && (rd_cnt == LAST_CNT)) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A read slot is lost whenever the writer takes the port
    always_comb begin
        rd_issue = 1'b0;
        free     = 1'b0;
        case (state)
            READ:    rd_issue = !wr_acc;
            DRAIN:   free     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            rd_pending   <= 1'b0;
            last_pending <= 1'b0;
            out_bank_q   <= 1'b0;
            bank_full_q  <= 1'b0;
        end else begin
            if (fill)        wr_cnt <= '0;
            else if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
            if (free)          rd_cnt <= '0;
            else if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
            rd_pending   <= rd_issue;
            last_pending <= rd_issue && (rd_cnt == LAST_CNT);
            bank_full_q  <= fill;
            if (state == IDLE && state_nxt == READ) out_bank_q <= rd_bank;
        end
    end

    assign bus.mem_en    = wr_acc || rd_issue;
    assign bus.mem_we    = wr_acc;
    assign bus.mem_addr  = wr_acc ? bank_base(wr_bank) + ADDR_W'(wr_cnt)
                                  : bank_base(rd_bank) + ADDR_W'(rd_cnt);
    assign bus.mem_wdata = bus.wr_data;

    assign bus.out_valid = rd_pending;
    assign bus.out_data  = bus.mem_rdata;
    assign bus.out_last  = last_pending;
    assign bus.out_bank  = out_bank_q;
    assign bus.bank_full = bank_full_q;
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl: a vector table for the basic write path,
// then hand-written frame sequences against a behavioural 1-cycle RAM.
module tb_pingpong_buf_ctrl;
    import pingpong_buf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pingpong_buf_ctrl_if bus();

    pingpong_buf_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:511];
    logic [15:0] rdata_q = 16'h0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata_q;

    typedef struct {
        logic        rst;
        logic        wv;
        logic [15:0] wd;
        logic        cr;
        logic        e_rdy;
        logic        e_en;
        logic        e_we;
        logic [8:0]  e_addr;
        logic        e_ov;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr_valid = 1'b0;
        bus.cons_ready = 1'b0;
        bus.wr_data = 16'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic write_frame(input logic [8:0] base, input logic [15:0] seed);
        for (int k = 0; k < 144; k++) begin
            tick();
            bus.wr_valid = 1'b1;
            bus.wr_data  = seed + 16'(k);
            #1;
            chk("wr_ready", bus.wr_ready, 1);
            chk("wr_en", bus.mem_en, 1);
            chk("wr_we", bus.mem_we, 1);
            chk("wr_addr", bus.mem_addr, base + 9'(k));
            chk("wr_wdata", bus.mem_wdata, seed + 16'(k));
            if (k > 0) chk("bank_full_early", bus.bank_full, 0);
        end
        tick();
        bus.wr_valid = 1'b0;
        #1;
        chk("bank_full_pulse", bus.bank_full, 1);
        chk("wr_idle_en", bus.mem_en, 0);
    endtask

    // mode 0: no writer traffic, 1: writer every other cycle, 2: writer held while blocked
    task automatic read_frame(input logic [8:0] rbase, input logic [15:0] seed, input logic bank,
                              input int mode, input logic [8:0] wbase, input logic [15:0] wseed,
                              inout int wi);
        int ri, pidx, t;
        bit pv;
        tick();
        bus.cons_ready = 1'b1;
        bus.wr_valid   = (mode == 2);
        bus.wr_data    = wseed + 16'(wi);
        #1;
        chk("rd_idle_en", bus.mem_en, 0);
        chk("rd_idle_ov", bus.out_valid, 0);
        if (mode == 2) chk("held_ready_idle", bus.wr_ready, 0);
        ri = 0; pidx = 0; t = 0; pv = 0;
        while (ri < 144 && t < 600) begin
            tick();
            bus.cons_ready = 1'b0;
            bus.wr_valid   = (mode == 2) || (mode == 1 && t % 2 == 1);
            bus.wr_data    = wseed + 16'(wi);
            #1;
            chk("out_valid", bus.out_valid, pv);
            if (pv) begin
                chk("out_data", bus.out_data, seed + 16'(pidx));
                chk("out_last", bus.out_last, pidx == 143);
                chk("out_bank", bus.out_bank, bank);
            end
            if (mode == 1 && bus.wr_valid) begin
                chk("ilv_wr_ready", bus.wr_ready, 1);
                chk("ilv_wr_en", bus.mem_en, 1);
                chk("ilv_wr_we", bus.mem_we, 1);
                chk("ilv_wr_addr", bus.mem_addr, wbase + 9'(wi));
                wi++;
                pv = 0;
            end else begin
                if (mode == 2) chk("held_ready", bus.wr_ready, 0);
                chk("rd_en", bus.mem_en, 1);
                chk("rd_we", bus.mem_we, 0);
                chk("rd_addr", bus.mem_addr, rbase + 9'(ri));
                pidx = ri;
                ri++;
                pv = 1;
            end
            t++;
        end
        if (ri < 144) chk("read_timeout", ri, 144);
        tick();
        bus.wr_valid = (mode == 2);
        #1;
        chk("drain_ov", bus.out_valid, 1);
        chk("drain_last", bus.out_last, 1);
        chk("drain_data", bus.out_data, seed + 16'd143);
        chk("drain_en", bus.mem_en, 0);
        if (mode == 2) chk("drain_ready", bus.wr_ready, 0);
        tick();
        bus.wr_valid = (mode == 2);
        #1;
        chk("post_ov", bus.out_valid, 0);
        chk("post_last", bus.out_last, 0);
        if (mode == 2) begin
            chk("post_ready", bus.wr_ready, 1);
            chk("post_we", bus.mem_we, 1);
            chk("post_addr", bus.mem_addr, wbase + 9'(wi));
            chk("post_wdata", bus.mem_wdata, wseed + 16'(wi));
            wi++;
        end else begin
            chk("post_en", bus.mem_en, 0);
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int wi;
        bus.wr_valid = 1'b0;
        bus.wr_data = 16'h0;
        bus.cons_ready = 1'b0;

        //            rst wv  wd       cr rdy en we addr ov
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, 1'b1, 9'd2, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0044, 1'b0, 1'b1, 1'b1, 1'b1, 9'd3, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0};

        do_reset();
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_bank", bus.out_bank, 0);
        chk("rst_bank_full", bus.bank_full, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);

        for (int i = 0; i < 10; i++) begin
            tick();
            reset          = vecs[i].rst;
            bus.wr_valid   = vecs[i].wv;
            bus.wr_data    = vecs[i].wd;
            bus.cons_ready = vecs[i].cr;
            #1;
            chk("vec_ready", bus.wr_ready, vecs[i].e_rdy);
            chk("vec_en", bus.mem_en, vecs[i].e_en);
            chk("vec_we", bus.mem_we, vecs[i].e_we);
            chk("vec_ov", bus.out_valid, vecs[i].e_ov);
            if (vecs[i].e_en) begin
                chk("vec_addr", bus.mem_addr, vecs[i].e_addr);
                chk("vec_wdata", bus.mem_wdata, vecs[i].wd);
            end
        end

        // fill bank 0, then the next write lands in bank 1, then read bank 0
        do_reset();
        write_frame(9'd0, 16'h1000);
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_data = 16'hBEEF;
        #1;
        chk("bank1_first_addr", bus.mem_addr, 200);
        chk("bank1_first_we", bus.mem_we, 1);
        tick();
        bus.wr_valid = 1'b0;
        wi = 0;
        read_frame(9'd0, 16'h1000, 1'b0, 0, 9'd0, 16'h0, wi);

        // both banks full: writer stalls until bank 0 drains, then word 289 goes to 0
        do_reset();
        write_frame(9'd0, 16'h2000);
        write_frame(9'd200, 16'h3000);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.wr_valid = 1'b1;
            bus.wr_data = 16'h4000;
            #1;
            chk("both_full_ready", bus.wr_ready, 0);
            chk("both_full_en", bus.mem_en, 0);
        end
        wi = 0;
        read_frame(9'd0, 16'h2000, 1'b0, 2, 9'd0, 16'h4000, wi);

        // read with writer active every other cycle
        do_reset();
        write_frame(9'd0, 16'h5000);
        wi = 0;
        read_frame(9'd0, 16'h5000, 1'b0, 1, 9'd200, 16'h6000, wi);
        chk("interleave_writes", wi, 143);

        // reset in the middle of a frame read
        do_reset();
        write_frame(9'd0, 16'h8000);
        tick();
        bus.cons_ready = 1'b1;
        #1;
        for (int i = 0; i < 70; i++) begin
            tick();
            bus.cons_ready = 1'b0;
            #1;
            chk("mid_rd_addr", bus.mem_addr, 9'(i));
            chk("mid_rd_en", bus.mem_en, 1);
        end
        tick();
        reset = 1'b1;
        #1;
        chk("mid_ov_before", bus.out_valid, 1);
        chk("mid_data_before", bus.out_data, 16'h8000 + 16'd69);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_ov_after", bus.out_valid, 0);
        chk("mid_ready_after", bus.wr_ready, 1);
        tick();
        bus.cons_ready = 1'b1;
        #1;
        chk("mid_no_read_en", bus.mem_en, 0);
        tick();
        bus.cons_ready = 1'b0;
        #1;
        chk("mid_no_read_en2", bus.mem_en, 0);
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_data = 16'h9999;
        #1;
        chk("mid_next_addr", bus.mem_addr, 0);
        chk("mid_next_we", bus.mem_we, 1);
        tick();
        bus.wr_valid = 1'b0;

        // four frames alternating banks
        do_reset();
        wi = 0;
        write_frame(9'd0, 16'h7000);
        write_frame(9'd200, 16'h7100);
        read_frame(9'd0, 16'h7000, 1'b0, 0, 9'd0, 16'h0, wi);
        write_frame(9'd0, 16'h7200);
        read_frame(9'd200, 16'h7100, 1'b1, 0, 9'd0, 16'h0, wi);
        write_frame(9'd200, 16'h7300);
        read_frame(9'd0, 16'h7200, 1'b0, 0, 9'd0, 16'h0, wi);
        read_frame(9'd200, 16'h7300, 1'b1, 0, 9'd0, 16'h0, wi);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
